// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one 1-bit full-adder slice stepped over WIDTH bits, LSB first.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input for two's-complement subtraction.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_bitSum;
  logic             w_bitCarry;
  logic [WIDTH-1:0] w_resNext;
  logic [WIDTH-1:0] w_bLoad;
  logic             w_cInit;

  // The shared 1-bit adder slice; its sum bit enters the result register from the top.
  assign w_bitSum   = r_aSr[0] ^ r_bSr[0] ^ r_c;
  assign w_bitCarry = (r_aSr[0] & r_bSr[0]) | (r_aSr[0] & r_c) | (r_bSr[0] & r_c);
  assign w_resNext  = {w_bitSum, r_res[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert B on load and preset the carry to 1.
  assign w_bLoad = sub ? ~b : b;
  assign w_cInit = sub;
`else
  assign w_bLoad = b;
  assign w_cInit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_aSr   <= '0;
      r_bSr   <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aSr   <= a;
            r_bSr   <= w_bLoad;
            r_c     <= w_cInit;
            r_cnt   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_aSr <= r_aSr >> 1;
          r_bSr <= r_bSr >> 1;
          r_c   <= w_bitCarry;
          r_res <= w_resNext;
          r_cnt <= r_cnt + CW'(1);
          // sum/carry update only here, so they hold the previous result through SHIFT.
          if (r_cnt == CW'(WIDTH - 1)) begin
            sum     <= w_resNext;
            carry   <= w_bitCarry;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): vector table, corner-case sequences and random ops.
// Build with SERIAL_ADD_SUB_EN defined to also exercise subtraction.
module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] expSum;
    logic         expCarry;
  } vec_t;

  vec_t vectors[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {carry, sum} of a full-width add, or no-borrow flag plus difference.
  function automatic logic [W:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    if (s) return {(x >= y), W'(x - y)};
    return W1'(x) + W1'(y);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Issues one op from IDLE (called at a negedge) and observes it until the DUT is idle again.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                               output logic [W-1:0] oSum, output logic oCarry,
                               output int busyCycles, output int doneIdx,
                               output logic doneAfter, output logic heldOk);
    logic [W-1:0] prevSum;
    logic         prevCarry;
    prevSum    = sum;
    prevCarry  = carry;
    heldOk     = 1'b1;
    oSum       = '0;
    oCarry     = 1'b0;
    busyCycles = 0;
    doneIdx    = -1;
    a = ia;
    b = ib;
`ifdef SERIAL_ADD_SUB_EN
    sub = isub;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = ~isub;
`endif
    for (int i = 0; i < W + 6; i++) begin
      if (done) begin
        doneIdx = i;
        oSum    = sum;
        oCarry  = carry;
        break;
      end
      if (busy) busyCycles++;
      if (sum !== prevSum || carry !== prevCarry) heldOk = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    doneAfter = done;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got 1 expected 0");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [W-1:0] rSum;
    logic         rCarry;
    int           rBusy;
    int           rDoneIdx;
    logic         rDoneAfter;
    logic         rHeld;
    logic [W:0]   expv;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           doneCount;
    int           firstIdx;
    int           secondIdx;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         c1;
    logic         c2;
    logic [W-1:0] recA;
    logic [W-1:0] recB;
    logic         busyIdle;
    logic         busyNew;
    logic         sawDone;

    vectors.push_back('{8'd3,   8'd5,   1'b0, 8'd8,   1'b0});
    vectors.push_back('{8'd255, 8'd1,   1'b0, 8'd0,   1'b1});
    vectors.push_back('{8'd0,   8'd0,   1'b0, 8'd0,   1'b0});
    vectors.push_back('{8'd170, 8'd85,  1'b0, 8'd255, 1'b0});
    vectors.push_back('{8'd1,   8'd1,   1'b0, 8'd2,   1'b0});
    vectors.push_back('{8'd200, 8'd100, 1'b0, 8'd44,  1'b1});
    vectors.push_back('{8'd128, 8'd128, 1'b0, 8'd0,   1'b1});
    vectors.push_back('{8'd255, 8'd255, 1'b0, 8'd254, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vectors.push_back('{8'd5,   8'd3,   1'b1, 8'd2,   1'b1});
    vectors.push_back('{8'd3,   8'd5,   1'b1, 8'd254, 1'b0});
    vectors.push_back('{8'd7,   8'd7,   1'b1, 8'd0,   1'b1});
    sub = 1'b0;
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    checkOutput("reset busy",  32'(busy),  32'd0);
    checkOutput("reset done",  32'(done),  32'd0);
    checkOutput("reset sum",   32'(sum),   32'd0);
    checkOutput("reset carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors with fixed expected results.
    foreach (vectors[k]) begin
      applyStimulus(vectors[k].a, vectors[k].b, vectors[k].sub,
                    rSum, rCarry, rBusy, rDoneIdx, rDoneAfter, rHeld);
      checkOutput($sformatf("vec%0d sum", k),       32'(rSum),       32'(vectors[k].expSum));
      checkOutput($sformatf("vec%0d carry", k),     32'(rCarry),     32'(vectors[k].expCarry));
      checkOutput($sformatf("vec%0d busyCyc", k),   32'(rBusy),      32'(W));
      checkOutput($sformatf("vec%0d doneAt", k),    32'(rDoneIdx),   32'(W));
      checkOutput($sformatf("vec%0d donePulse", k), 32'(rDoneAfter), 32'd0);
      checkOutput($sformatf("vec%0d heldSum", k),   32'(rHeld),      32'd1);
    end

    // Start held high for a whole op while operands keep changing.
    doneCount = 0;
    firstIdx  = -1;
    secondIdx = -1;
    s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    recA = '0; recB = '0; busyIdle = 1'b1; busyNew = 1'b0;
    a = 8'd10;
    b = 8'd20;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * W + 5; i++) begin
      if (done) begin
        doneCount++;
        if (firstIdx < 0) begin
          firstIdx = i; s1 = sum; c1 = carry;
        end else begin
          secondIdx = i; s2 = sum; c2 = carry;
        end
      end
      if (i == W + 1) busyIdle = busy;
      if (i == W + 2) busyNew = busy;
      a = W'(i * 37 + 3);
      b = W'(i * 91 + 11);
      if (i == W + 1) begin
        recA = a;
        recB = b;
      end
      if (i >= W + 2) start = 1'b0;
      @(negedge clk);
    end
    expv = refModel(recA, recB, 1'b0);
    checkOutput("held firstDoneAt", 32'(firstIdx),  32'(W));
    checkOutput("held firstSum",    32'(s1),        32'd30);
    checkOutput("held firstCarry",  32'(c1),        32'd0);
    checkOutput("held idleGap",     32'(busyIdle),  32'd0);
    checkOutput("held restart",     32'(busyNew),   32'd1);
    checkOutput("held secondAt",    32'(secondIdx), 32'(2 * W + 2));
    checkOutput("held doneCount",   32'(doneCount), 32'd2);
    checkOutput("held secondSum",   32'(s2),        32'(expv[W-1:0]));
    checkOutput("held secondCarry", 32'(c2),        32'(expv[W]));

    // Reset asserted during the fourth SHIFT cycle.
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort busyBefore", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy",  32'(busy),  32'd0);
    checkOutput("abort done",  32'(done),  32'd0);
    checkOutput("abort sum",   32'(sum),   32'd0);
    checkOutput("abort carry", 32'(carry), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort noDone", 32'(sawDone), 32'd0);
    applyStimulus(8'd200, 8'd100, 1'b0, rSum, rCarry, rBusy, rDoneIdx, rDoneAfter, rHeld);
    checkOutput("abort redoSum",   32'(rSum),   32'd44);
    checkOutput("abort redoCarry", 32'(rCarry), 32'd1);

    // Back-to-back ops: the first result must hold through the second op's SHIFT cycles.
    applyStimulus(8'd170, 8'd85, 1'b0, rSum, rCarry, rBusy, rDoneIdx, rDoneAfter, rHeld);
    checkOutput("b2b firstSum",   32'(rSum),   32'd255);
    checkOutput("b2b firstCarry", 32'(rCarry), 32'd0);
    applyStimulus(8'd1, 8'd1, 1'b0, rSum, rCarry, rBusy, rDoneIdx, rDoneAfter, rHeld);
    checkOutput("b2b heldDuringShift", 32'(rHeld),  32'd1);
    checkOutput("b2b secondSum",       32'(rSum),   32'd2);
    checkOutput("b2b secondCarry",     32'(rCarry), 32'd0);

    // Random operands against the reference arithmetic.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      expv = refModel(ra, rb, rs);
      applyStimulus(ra, rb, rs, rSum, rCarry, rBusy, rDoneIdx, rDoneAfter, rHeld);
      checkOutput($sformatf("rand%0d sum a=%0d b=%0d s=%0d", n, ra, rb, rs),
                  32'(rSum), 32'(expv[W-1:0]));
      checkOutput($sformatf("rand%0d carry", n),  32'(rCarry),   32'(expv[W]));
      checkOutput($sformatf("rand%0d doneAt", n), 32'(rDoneIdx), 32'(W));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
